// File: rtl/poly_voice_allocator.sv
// Polyphonic voice allocator: scans the key lines, turns snapshot edges into
// note-on/note-off events and maps them onto a pool of voice slots with
// gate, timed release and oldest-first stealing.
module poly_voice_allocator #(
  parameter int NUM_KEYS       = 88,
  parameter int NUM_VOICES     = 8,
  parameter int KEY_W          = 7,
  parameter int AGE_W          = 8,
  parameter int RELEASE_CYCLES = 1024
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [NUM_KEYS-1:0]         iKEYS,
  output logic [NUM_VOICES*KEY_W-1:0] oVOICE_KEY,
  output logic [NUM_VOICES-1:0]       oVOICE_GATE,
  output logic [NUM_VOICES-1:0]       oVOICE_BUSY,
  output logic [NUM_VOICES-1:0]       oVOICE_TRIG,
  output logic                        oKEY_PRESSED,
  output logic                        oSCAN_DONE
);

  localparam int CNT_W  = $clog2(RELEASE_CYCLES + 1);
  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYCLES);

  typedef enum logic [1:0] {
    V_IDLE    = 2'd0,
    V_ACTIVE  = 2'd1,
    V_RELEASE = 2'd2
  } voice_state_t;

  // ---------------------------------------------------------------------------
  // Scanner
  // ---------------------------------------------------------------------------
  logic [KEY_W-1:0]    ptr_reg, ptr_next;
  logic [NUM_KEYS-1:0] snap_reg, prev_reg;
  logic [NUM_KEYS-1:0] key_sel;
  logic                scan_done_reg, key_pressed_reg;
  logic                note_on, note_off;

  genvar gi;

  // One-hot decode of the scan pointer; avoids a variable bit-select whose
  // index width would not match the vector when 2^KEY_W > NUM_KEYS.
  for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key_sel
    assign key_sel[gi] = (ptr_reg == KEY_W'(gi));
  end

  assign ptr_next = (ptr_reg == LAST_KEY) ? '0 : ptr_reg + 1'b1;
  assign note_on  = |(snap_reg & ~prev_reg & key_sel);
  assign note_off = |(~snap_reg & prev_reg & key_sel);

  // Scan pointer, key snapshot, per-key previous state and scan flags.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ptr_reg         <= '0;
      snap_reg        <= '0;
      prev_reg        <= '0;
      scan_done_reg   <= 1'b0;
      key_pressed_reg <= 1'b0;
    end else begin
      ptr_reg         <= ptr_next;
      prev_reg        <= (prev_reg & ~key_sel) | (snap_reg & key_sel);
      if (ptr_reg == LAST_KEY) begin
        snap_reg <= iKEYS;
      end
      scan_done_reg   <= (ptr_next == LAST_KEY);
      key_pressed_reg <= |snap_reg;
    end
  end

  assign oSCAN_DONE   = scan_done_reg;
  assign oKEY_PRESSED = key_pressed_reg;

  // ---------------------------------------------------------------------------
  // Voice selection
  // ---------------------------------------------------------------------------
  logic [NUM_VOICES-1:0]       idle_vec, active_vec, release_vec, holds_key_vec;
  logic [NUM_VOICES-1:0]       alloc_mask, off_mask;
  logic [NUM_VOICES*AGE_W-1:0] age_flat;

  logic              found, rel_cand, act_cand, off_taken;
  logic [AGE_W-1:0]  rel_best, act_best;
  logic [VIDX_W-1:0] alloc_idx, rel_idx, act_idx;

  // Note-on target: retrigger, then lowest idle, then oldest release, then
  // oldest active. Strict '>' keeps the lowest index on age ties.
  always_comb begin
    found     = 1'b0;
    alloc_idx = '0;
    rel_cand  = 1'b0;
    act_cand  = 1'b0;
    rel_best  = '0;
    act_best  = '0;
    rel_idx   = '0;
    act_idx   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!found && release_vec[v] && holds_key_vec[v]) begin
        found     = 1'b1;
        alloc_idx = VIDX_W'(v);
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!found && idle_vec[v]) begin
        found     = 1'b1;
        alloc_idx = VIDX_W'(v);
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (release_vec[v] && (!rel_cand || age_flat[v*AGE_W +: AGE_W] > rel_best)) begin
        rel_cand = 1'b1;
        rel_best = age_flat[v*AGE_W +: AGE_W];
        rel_idx  = VIDX_W'(v);
      end
      if (active_vec[v] && (!act_cand || age_flat[v*AGE_W +: AGE_W] > act_best)) begin
        act_cand = 1'b1;
        act_best = age_flat[v*AGE_W +: AGE_W];
        act_idx  = VIDX_W'(v);
      end
    end
    if (!found && rel_cand) begin
      found     = 1'b1;
      alloc_idx = rel_idx;
    end
    if (!found && act_cand) begin
      alloc_idx = act_idx;
    end
  end

  // Note-off target: the active voice holding the key; a stolen key has none.
  always_comb begin
    off_mask  = '0;
    off_taken = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (note_off && !off_taken && active_vec[v] && holds_key_vec[v]) begin
        off_mask[v] = 1'b1;
        off_taken   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-voice state machines
  // ---------------------------------------------------------------------------
  for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    voice_state_t     state_reg, state_next;
    logic [KEY_W-1:0] key_reg, key_next;
    logic [AGE_W-1:0] age_reg, age_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             trig_next;
    logic             gate_reg, busy_reg, trig_reg;

    assign idle_vec[gi]      = (state_reg == V_IDLE);
    assign active_vec[gi]    = (state_reg == V_ACTIVE);
    assign release_vec[gi]   = (state_reg == V_RELEASE);
    assign holds_key_vec[gi] = (key_reg == ptr_reg);
    assign age_flat[gi*AGE_W +: AGE_W] = age_reg;
    assign alloc_mask[gi]    = note_on && (alloc_idx == VIDX_W'(gi));

    // Next state: allocation wins over note-off handling and release countdown.
    always_comb begin
      state_next = state_reg;
      key_next   = key_reg;
      age_next   = age_reg;
      cnt_next   = cnt_reg;
      trig_next  = 1'b0;
      if (alloc_mask[gi]) begin
        state_next = V_ACTIVE;
        key_next   = ptr_reg;
        age_next   = '0;
        cnt_next   = '0;
        trig_next  = 1'b1;
      end else begin
        if (note_on && (state_reg != V_IDLE) && (age_reg != AGE_MAX)) begin
          age_next = age_reg + 1'b1;
        end
        case (state_reg)
          V_ACTIVE: begin
            if (off_mask[gi]) begin
              state_next = V_RELEASE;
              cnt_next   = REL_LOAD;
            end
          end
          V_RELEASE: begin
            if (cnt_reg == CNT_W'(1)) begin
              state_next = V_IDLE;
            end
            cnt_next = cnt_reg - 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Voice state register with registered gate/busy/trig outputs.
    always_ff @(posedge iCLK) begin
      if (iRST) begin
        state_reg <= V_IDLE;
        key_reg   <= '0;
        age_reg   <= '0;
        cnt_reg   <= '0;
        gate_reg  <= 1'b0;
        busy_reg  <= 1'b0;
        trig_reg  <= 1'b0;
      end else begin
        state_reg <= state_next;
        key_reg   <= key_next;
        age_reg   <= age_next;
        cnt_reg   <= cnt_next;
        gate_reg  <= (state_next == V_ACTIVE);
        busy_reg  <= (state_next != V_IDLE);
        trig_reg  <= trig_next;
      end
    end

    assign oVOICE_KEY[gi*KEY_W +: KEY_W] = key_reg;
    assign oVOICE_GATE[gi] = gate_reg;
    assign oVOICE_BUSY[gi] = busy_reg;
    assign oVOICE_TRIG[gi] = trig_reg;
  end

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Testbench for poly_voice_allocator: directed scenarios plus randomized key
// traffic checked against an event-level reference model.
module tb_poly_voice_allocator;

  localparam int NK = 12;
  localparam int NV = 4;
  localparam int KW = 7;
  localparam int AW = 8;
  localparam int RC = 16;
  localparam int OW = NV*KW + 3*NV + 2;

  localparam int S_IDLE = 0;
  localparam int S_ACT  = 1;
  localparam int S_REL  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NK-1:0]     keys;
  logic [NV*KW-1:0]  voice_key;
  logic [NV-1:0]     voice_gate, voice_busy, voice_trig;
  logic              key_pressed, scan_done;

  int test_cnt = 0;
  int fail_cnt = 0;

  poly_voice_allocator #(
    .NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW), .AGE_W(AW), .RELEASE_CYCLES(RC)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .iKEYS(keys),
    .oVOICE_KEY(voice_key),
    .oVOICE_GATE(voice_gate),
    .oVOICE_BUSY(voice_busy),
    .oVOICE_TRIG(voice_trig),
    .oKEY_PRESSED(key_pressed),
    .oSCAN_DONE(scan_done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: edges counted in absolute time, voice age derived from
  // allocation serial numbers, release end stored as an absolute edge number.
  // ---------------------------------------------------------------------------
  int            m_cyc, m_pos, m_allocs;
  logic [NK-1:0] m_snap, m_prev;
  int            m_state  [NV];
  int            m_key    [NV];
  int            m_serial [NV];
  int            m_rel_end[NV];
  logic [NV-1:0] m_trig;
  logic          m_scan_done, m_key_pressed;

  function automatic void model_reset();
    m_cyc = 0; m_pos = 0; m_allocs = 0;
    m_snap = '0; m_prev = '0; m_trig = '0;
    m_scan_done = 1'b0; m_key_pressed = 1'b0;
    for (int v = 0; v < NV; v++) begin
      m_state[v] = S_IDLE; m_key[v] = 0; m_serial[v] = 0; m_rel_end[v] = 0;
    end
  endfunction

  function automatic int m_age(int v);
    int a;
    a = m_allocs - m_serial[v];
    return (a > 255) ? 255 : a;
  endfunction

  function automatic void model_edge(logic [NK-1:0] k);
    int  p, pick, best;
    bit  on, off, done;
    p = m_pos;
    m_cyc++;
    for (int v = 0; v < NV; v++)
      if (m_state[v] == S_REL && m_cyc > m_rel_end[v]) m_state[v] = S_IDLE;
    on  = m_snap[p] && !m_prev[p];
    off = !m_snap[p] && m_prev[p];
    m_trig = '0;
    if (on) begin
      pick = -1;
      for (int v = 0; v < NV; v++) if (pick < 0 && m_state[v] == S_REL && m_key[v] == p) pick = v;
      for (int v = 0; v < NV; v++) if (pick < 0 && m_state[v] == S_IDLE) pick = v;
      if (pick < 0) begin
        best = -1;
        for (int v = 0; v < NV; v++) if (m_state[v] == S_REL && m_age(v) > best) begin best = m_age(v); pick = v; end
      end
      if (pick < 0) begin
        best = -1;
        for (int v = 0; v < NV; v++) if (m_state[v] == S_ACT && m_age(v) > best) begin best = m_age(v); pick = v; end
      end
      m_allocs++;
      m_state[pick] = S_ACT; m_key[pick] = p; m_serial[pick] = m_allocs; m_trig[pick] = 1'b1;
    end
    if (off) begin
      done = 0;
      for (int v = 0; v < NV; v++)
        if (!done && m_state[v] == S_ACT && m_key[v] == p) begin
          done = 1; m_state[v] = S_REL; m_rel_end[v] = m_cyc + RC;
        end
    end
    m_prev[p] = m_snap[p];
    m_key_pressed = |m_snap;
    if (p == NK-1) m_snap = k;
    m_pos = (p + 1) % NK;
    m_scan_done = (m_pos == NK-1);
  endfunction

  function automatic logic [OW-1:0] exp_all();
    logic [NV*KW-1:0] kv;
    logic [NV-1:0]    g, b;
    for (int v = 0; v < NV; v++) begin
      kv[v*KW +: KW] = KW'(m_key[v]);
      g[v] = (m_state[v] == S_ACT);
      b[v] = (m_state[v] == S_ACT) || (m_state[v] == S_REL && m_cyc < m_rel_end[v]);
    end
    return {kv, g, b, m_trig, m_key_pressed, m_scan_done};
  endfunction

  function automatic logic [OW-1:0] dut_all();
    return {voice_key, voice_gate, voice_busy, voice_trig, key_pressed, scan_done};
  endfunction

  // One clock: model follows the DUT edge, outputs are then sampled at negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(keys);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int pulses;
    rst = 1'b1; keys = '0;
    tick(); tick();
    test_cnt++;
    if (dut_all() !== '0) begin
      fail_cnt++; $display("FAIL reset_outputs: got %h want 0", dut_all());
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (scan_done) pulses++;
      test_cnt++;
      if (scan_done !== ((i % 12) == 10)) begin
        fail_cnt++; $display("FAIL scan_done_phase: cycle %0d got %b want %b", i, scan_done, (i % 12) == 10);
      end
      test_cnt++;
      if (dut_all() !== exp_all()) begin
        fail_cnt++; $display("FAIL reset_idle_model: cycle %0d got %h want %h", i, dut_all(), exp_all());
      end
    end
    test_cnt++;
    if (pulses != 3) begin
      fail_cnt++; $display("FAIL scan_done_count: got %0d want 3", pulses);
    end
    test_cnt++;
    if ({voice_gate, voice_busy, voice_trig, key_pressed} !== '0) begin
      fail_cnt++; $display("FAIL idle_outputs: got %h want 0", {voice_gate, voice_busy, voice_trig, key_pressed});
    end
  endtask

  task automatic test_single_press();
    bit seen;
    keys = NK'(1) << 5;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      test_cnt++;
      if (dut_all() !== exp_all()) begin
        fail_cnt++; $display("FAIL press_model: got %h want %h", dut_all(), exp_all());
      end
      if (voice_trig != '0) seen = 1;
    end
    test_cnt++;
    if (!seen) begin
      fail_cnt++; $display("FAIL press_timeout: trig got 0 want 0001");
    end
    test_cnt++;
    if ({voice_key[KW-1:0], voice_gate, voice_busy, voice_trig, key_pressed} !== {7'd5, 4'b0001, 4'b0001, 4'b0001, 1'b1}) begin
      fail_cnt++; $display("FAIL press_voice0: key %0d gate %b busy %b trig %b kp %b want 5 0001 0001 0001 1",
                           voice_key[KW-1:0], voice_gate, voice_busy, voice_trig, key_pressed);
    end
    tick();
    test_cnt++;
    if (voice_trig !== 4'b0000) begin
      fail_cnt++; $display("FAIL trig_width: got %b want 0000", voice_trig);
    end
  endtask

  task automatic test_release();
    bit fell;
    int busy_len;
    keys = '0;
    fell = 0;
    for (int i = 0; i < 40 && !fell; i++) begin
      tick();
      if (!voice_gate[0]) fell = 1;
    end
    test_cnt++;
    if (!fell || !voice_busy[0]) begin
      fail_cnt++; $display("FAIL release_start: gate %b busy %b want 0 1", voice_gate[0], voice_busy[0]);
    end
    busy_len = voice_busy[0] ? 1 : 0;
    for (int i = 0; i < 30 && voice_busy[0]; i++) begin
      tick();
      test_cnt++;
      if (dut_all() !== exp_all()) begin
        fail_cnt++; $display("FAIL release_model: got %h want %h", dut_all(), exp_all());
      end
      if (voice_busy[0]) busy_len++;
    end
    test_cnt++;
    if (busy_len != RC) begin
      fail_cnt++; $display("FAIL release_length: got %0d want %0d", busy_len, RC);
    end
  endtask

  task automatic test_retrigger();
    bit seen, fell, gap;
    keys = NK'(1) << 5;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (voice_trig != '0) seen = 1;
    end
    keys = '0;
    fell = 0;
    for (int i = 0; i < 40 && !fell; i++) begin
      tick();
      if (!voice_gate[0]) fell = 1;
    end
    keys = NK'(1) << 5;
    seen = 0; gap = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (!voice_busy[0]) gap = 1;
      test_cnt++;
      if (dut_all() !== exp_all()) begin
        fail_cnt++; $display("FAIL retrig_model: got %h want %h", dut_all(), exp_all());
      end
      if (voice_trig != '0) seen = 1;
    end
    test_cnt++;
    if (!seen || gap || voice_trig !== 4'b0001 || voice_busy[1] !== 1'b0 || voice_key[KW-1:0] !== 7'd5) begin
      fail_cnt++; $display("FAIL retrigger: seen %b gap %b trig %b busy %b key0 %0d want 1 0 0001 busy1=0 5",
                           seen, gap, voice_trig, voice_busy, voice_key[KW-1:0]);
    end
    keys = '0;
    run(60);
  endtask

  task automatic test_steal();
    int trig0;
    keys = '0;
    for (int kk = 1; kk <= 4; kk++) begin
      keys[kk] = 1'b1;
      run(12);
    end
    keys[7] = 1'b1;
    trig0 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (voice_trig[0]) trig0++;
      test_cnt++;
      if (dut_all() !== exp_all()) begin
        fail_cnt++; $display("FAIL steal_model: got %h want %h", dut_all(), exp_all());
      end
    end
    test_cnt++;
    if (voice_key !== {7'd4, 7'd3, 7'd2, 7'd7} || voice_gate !== 4'b1111 || trig0 != 1) begin
      fail_cnt++; $display("FAIL steal_oldest: keys %h gate %b trig0 %0d want %h 1111 1",
                           voice_key, voice_gate, trig0, {7'd4, 7'd3, 7'd2, 7'd7});
    end
    keys = '0;
    run(60);
  endtask

  task automatic test_ignored_off();
    logic [OW-1:0] hold;
    bit            any_trig;
    keys = '0;
    keys[0] = 1'b1; keys[3] = 1'b1; keys[6] = 1'b1; keys[8] = 1'b1; keys[10] = 1'b1;
    run(30);
    test_cnt++;
    if (voice_key !== {7'd8, 7'd6, 7'd3, 7'd10} || voice_gate !== 4'b1111) begin
      fail_cnt++; $display("FAIL five_keys: keys %h gate %b want %h 1111", voice_key, voice_gate, {7'd8, 7'd6, 7'd3, 7'd10});
    end
    hold = dut_all();
    keys[0] = 1'b0;
    any_trig = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (voice_trig != '0) any_trig = 1;
      test_cnt++;
      if ({voice_key, voice_gate, voice_busy} !== hold[OW-1:NV+2]) begin
        fail_cnt++; $display("FAIL ignored_off: got %h want %h", {voice_key, voice_gate, voice_busy}, hold[OW-1:NV+2]);
      end
    end
    test_cnt++;
    if (any_trig) begin
      fail_cnt++; $display("FAIL ignored_off_trig: got 1 want 0");
    end
    keys = '0;
    run(60);
  endtask

  task automatic test_reset_mid_release();
    bit ready, seen;
    keys = '0;
    keys[2] = 1'b1; keys[9] = 1'b1;
    run(30);
    keys = '0;
    ready = 0;
    for (int i = 0; i < 40 && !ready; i++) begin
      tick();
      if (voice_gate == '0 && voice_busy != '0) ready = 1;
    end
    test_cnt++;
    if (!ready) begin
      fail_cnt++; $display("FAIL mid_release_setup: gate %b busy %b want 0000 nonzero", voice_gate, voice_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_cnt++;
    if ({voice_key, voice_gate, voice_busy, voice_trig} !== '0) begin
      fail_cnt++; $display("FAIL reset_abort: got %h want 0", {voice_key, voice_gate, voice_busy, voice_trig});
    end
    keys = NK'(1) << 9;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (voice_trig != '0) seen = 1;
    end
    test_cnt++;
    if (!seen || voice_trig !== 4'b0001 || voice_key[KW-1:0] !== 7'd9) begin
      fail_cnt++; $display("FAIL post_reset_alloc: trig %b key0 %0d want 0001 9", voice_trig, voice_key[KW-1:0]);
    end
    keys = '0;
    run(60);
  endtask

  task automatic test_back_to_back_random();
    int idx;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, NK-1);
        keys[idx] = ~keys[idx];
      end
      rst = ($urandom_range(0, 799) == 0);
      tick();
      rst = 1'b0;
      test_cnt++;
      if (dut_all() !== exp_all()) begin
        fail_cnt++; $display("FAIL random_model: cycle %0d got %h want %h", i, dut_all(), exp_all());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    keys = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_press();
    test_release();
    test_retrigger();
    test_steal();
    test_ignored_off();
    test_reset_mid_release();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
